conv_mac_sequencer: RTL and testbench

Sequences one convolution window through the Q5.11 fixed-point multiply/saturate/accumulate path of the CNN accelerator. Accepts `N_TAPS` pixel/weight pairs over a valid/ready stream, saturates each product and each partial sum to Q5.11, and presents the window result on an output valid/ready port. Sits between the window fetch logic and the output feature-map writer; one instance per convolution lane.

---
 rtl/conv_mac_sequencer.sv | 79 +++++++
 tb/tb_conv_mac_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: one convolution window through a Q5.11 saturating multiply-accumulate path.
//   Ports: clk, rst (async, active-high); start/busy window control; bias (Q5.11, latched on start);
//   in_valid/in_ready with pixel/weight (Q5.11 pairs); out_valid/out_ready with out_data (Q5.11 result);
//   sat_flag (sticky clamp indicator for the window); tap_count (pairs accepted in the window).
//   Optional feature: define CONV_MAC_BIAS_EN to seed the accumulator with bias instead of zero.
module conv_mac_sequencer #(
    parameter int N_TAPS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    input  logic [15:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] pixel,
    input  logic [15:0] weight,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        sat_flag,
    output logic [7:0]  tap_count
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [7:0] LAST = 8'(N_TAPS - 1);
    state_t state;
    logic [15:0] acc;
    logic [15:0] init;
    logic signed [31:0] prod;
    logic mul_sat;
    logic [15:0] mul_val;
    logic signed [16:0] sum;
    logic add_sat;
    logic [15:0] add_val;
`ifdef CONV_MAC_BIAS_EN
    assign init = bias;
`else
    logic unused_bias;
    assign unused_bias = ^bias;
    assign init = '0;
`endif
    assign prod = $signed(pixel) * $signed(weight);
    // Integer field [31:22] fits Q5.11 only when bits [31:26] are all sign copies.
    assign mul_sat = !((&prod[31:26]) || !(|prod[31:26]));
    assign mul_val = mul_sat ? (prod[31] ? 16'h8000 : 16'h7FFF) : prod[26:11];
    assign sum = {acc[15], acc} + {mul_val[15], mul_val};
    // Integer field [16:11] fits Q5.11 only when bits 16 and 15 agree.
    assign add_sat = sum[16] ^ sum[15];
    assign add_val = add_sat ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];
    assign busy = state != IDLE;
    assign in_ready = state == ACCUM;
    assign out_valid = state == DONE;
    assign out_data = acc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            tap_count <= '0;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= ACCUM;
                    acc       <= init;
                    tap_count <= '0;
                    sat_flag  <= 1'b0;
                end
                ACCUM: if (in_valid) begin
                    acc       <= add_val;
                    tap_count <= tap_count + 8'd1;
                    sat_flag  <= sat_flag | mul_sat | add_sat;
                    if (tap_count == LAST) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb_conv_mac_sequencer: randomized and directed self-checking bench for conv_mac_sequencer.
module tb_conv_mac_sequencer;
    localparam int NT = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic [15:0] bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] pixel = '0;
    logic [15:0] weight = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        sat_flag;
    logic [7:0]  tap_count;

    conv_mac_sequencer #(.N_TAPS(NT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel), .weight(weight),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag), .tap_count(tap_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 collecting pairs, 2 result waiting; the result is
    // recomputed from the list of accepted pairs with plain integer arithmetic.
    int          m_phase = 0;
    int          m_n = 0;
    bit          m_fresh = 1'b1;
    logic [15:0] m_bias = '0;
    logic [15:0] m_px [0:255];
    logic [15:0] m_wt [0:255];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_n     <= 0;
            m_bias  <= '0;
            m_fresh <= 1'b1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_n     <= 0;
                m_bias  <= bias;
                m_fresh <= 1'b0;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_px[m_n] <= pixel;
                m_wt[m_n] <= weight;
                m_n       <= m_n + 1;
                if (m_n + 1 == NT) m_phase <= 2;
            end
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    function automatic void model_eval(output int acc, output bit sat);
        int pr;
        int q;
`ifdef CONV_MAC_BIAS_EN
        acc = int'($signed(m_bias));
`else
        acc = 0;
`endif
        sat = 1'b0;
        for (int i = 0; i < m_n; i++) begin
            pr = int'($signed(m_px[i])) * int'($signed(m_wt[i]));
            if (pr >= (16 << 22)) begin q = 32767; sat = 1'b1; end
            else if (pr < -(16 << 22)) begin q = -32768; sat = 1'b1; end
            else q = pr >>> 11;
            acc = acc + q;
            if (acc > 32767) begin acc = 32767; sat = 1'b1; end
            else if (acc < -32768) begin acc = -32768; sat = 1'b1; end
        end
    endfunction

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // Hand-computed expectations for directed windows, checked while the result is presented.
    bit          lit_en = 1'b0;
    logic [15:0] lit_data = '0;
    bit          lit_sat = 1'b0;

    always @(negedge clk) begin
        int macc;
        bit msat;
        model_eval(macc, msat);
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("in_ready", int'(in_ready), int'(m_phase == 1));
        chk("out_valid", int'(out_valid), int'(m_phase == 2));
        chk("tap_count", int'(tap_count), m_n);
        chk("sat_flag", int'(sat_flag), int'(msat));
        if (m_phase == 2) chk("out_data", int'(out_data), macc & 32'hFFFF);
        if (m_fresh) chk("out_data_reset", int'(out_data), 0);
        if (lit_en && out_valid) begin
            chk("lit_data", int'(out_data), int'(lit_data));
            chk("lit_sat", int'(sat_flag), int'(lit_sat));
            chk("lit_taps", int'(tap_count), NT);
        end
    end

    task automatic do_start(input logic [15:0] b);
        start = 1'b1;
        bias  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] p, input logic [15:0] w, input bit gap);
        in_valid = 1'b1;
        pixel    = p;
        weight   = w;
        @(negedge clk);
        in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic expect_lit(input logic [15:0] d, input bit s);
        lit_data = d;
        lit_sat  = s;
        lit_en   = 1'b1;
    endtask

    task automatic take_result(input int hold, input bit poke_start);
        int k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            $display("FAIL out_valid_timeout at %0t: got 0 expected 1", $time);
            $fatal(1);
        end
        for (int i = 0; i < hold; i++) begin
            start = poke_start && (i % 3 == 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        start = poke_start;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        lit_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic window4(input logic [15:0] p, input logic [15:0] w, input bit gap);
        for (int i = 0; i < NT; i++) send(p, w, gap);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        expect_lit(16'h2000, 1'b0);
        do_start(16'h0000);
        window4(16'h0800, 16'h0800, 1'b0);
        take_result(0, 1'b0);

        expect_lit(16'h7FFF, 1'b1);
        do_start(16'h0000);
        send(16'h7FFF, 16'h1000, 1'b0);
        for (int i = 1; i < NT; i++) send(16'h0000, 16'h0000, 1'b0);
        take_result(2, 1'b0);

        expect_lit(16'h7FFF, 1'b1);
        do_start(16'h0000);
        window4(16'h4000, 16'h0800, 1'b0);
        take_result(0, 1'b0);

        expect_lit(16'hE000, 1'b0);
        do_start(16'h0000);
        window4(16'hF800, 16'h0800, 1'b0);
        take_result(1, 1'b0);

`ifdef CONV_MAC_BIAS_EN
        expect_lit(16'h1400, 1'b0);
`else
        expect_lit(16'h1000, 1'b0);
`endif
        do_start(16'h0400);
        send(16'h0800, 16'h0800, 1'b0);
        send(16'h0800, 16'h0800, 1'b0);
        send(16'h0000, 16'h0000, 1'b0);
        send(16'h0000, 16'h0000, 1'b0);
        take_result(0, 1'b0);

        expect_lit(16'h2000, 1'b0);
        do_start(16'h0000);
        window4(16'h0800, 16'h0800, 1'b1);
        take_result(10, 1'b1);

        do_start(16'h0000);
        send(16'h4000, 16'h4000, 1'b0);
        send(16'h4000, 16'h4000, 1'b0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        expect_lit(16'h2000, 1'b0);
        do_start(16'h0000);
        window4(16'h0800, 16'h0800, 1'b0);
        take_result(0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom % 4) == 0;
            bias      = 16'($urandom);
            in_valid  = ($urandom % 4) != 0;
            pixel     = 16'($urandom);
            weight    = 16'($urandom);
            if ($urandom % 2) pixel = {{4{pixel[11]}}, pixel[11:0]};
            if ($urandom % 2) weight = {{4{weight[11]}}, weight[11:0]};
            out_ready = ($urandom % 2) == 0;
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
